// File: rtl/output_spike_buffer_pkg.sv
// Shared sizing helpers and entry layout for the output spike buffer.
// Host-side CSR decode uses the same field offsets to unpack host_dout.
package output_spike_buffer_pkg;

  function automatic int calc_idx_w(input int num_outputs);
    return (num_outputs > 1) ? $clog2(num_outputs) : 1;
  endfunction

  function automatic int calc_entry_w(input int tag_w, input int num_outputs);
    return tag_w + calc_idx_w(num_outputs);
  endfunction

  // Entry layout is {tick_tag, index}: the index sits in the low bits.
  function automatic int idx_msb(input int num_outputs);
    return calc_idx_w(num_outputs) - 1;
  endfunction

  function automatic int tag_lsb(input int num_outputs);
    return calc_idx_w(num_outputs);
  endfunction

  function automatic int tag_msb(input int tag_w, input int num_outputs);
    return calc_entry_w(tag_w, num_outputs) - 1;
  endfunction

  // Offsets for the default build (256 outputs, 8-bit tick tag).
  localparam int DEF_NUM_OUTPUTS    = 256;
  localparam int DEF_TICK_TAG_WIDTH = 8;
  localparam int IDX_W   = calc_idx_w(DEF_NUM_OUTPUTS);
  localparam int ENTRY_W = calc_entry_w(DEF_TICK_TAG_WIDTH, DEF_NUM_OUTPUTS);
  localparam int IDX_LSB = 0;
  localparam int IDX_MSB = idx_msb(DEF_NUM_OUTPUTS);
  localparam int TAG_LSB = tag_lsb(DEF_NUM_OUTPUTS);
  localparam int TAG_MSB = tag_msb(DEF_TICK_TAG_WIDTH, DEF_NUM_OUTPUTS);

  // What happens to the incoming packet this cycle.
  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ACCEPT,
    WR_DROP,
    WR_FLUSH
  } wr_action_e;

endpackage

// File: rtl/spike_fifo_sync.sv
// Generic first-word-fall-through synchronous FIFO with a registered count.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module spike_fifo_sync #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_rd = rd_en & ~empty & ~flush;
  assign do_wr = wr_en & (~full | do_rd) & ~flush;

  // Head is visible straight from the read pointer; zeros while empty.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: the storage array has no reset; the pointers alone define which
  // words are valid, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_wr) - CNT_W'(do_rd);
    end
  end

endmodule

// File: rtl/output_spike_buffer.sv
// Tick-stamps output-neuron indices and queues them for the host, with
// occupancy, saturating drop count, sticky overflow and a level interrupt.
module output_spike_buffer
  import output_spike_buffer_pkg::*;
#(
  parameter  int NUM_OUTPUTS    = 256,
  parameter  int TICK_TAG_WIDTH = 8,
  parameter  int FIFO_DEPTH     = 64,
  parameter  int DROP_CNT_WIDTH = 16,
  parameter  int IRQ_THRESHOLD  = 32,
  localparam int PKT_W          = calc_idx_w(NUM_OUTPUTS),
  localparam int ENT_W          = calc_entry_w(TICK_TAG_WIDTH, NUM_OUTPUTS),
  localparam int CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [PKT_W-1:0]          packet_in,
  input  logic                      packet_in_valid,
  input  logic                      tick,
  input  logic                      clear,
  input  logic                      host_ren,
  output logic [ENT_W-1:0]          host_dout,
  output logic                      host_empty,
  output logic [CNT_W-1:0]          host_count,
  output logic [TICK_TAG_WIDTH-1:0] tick_count,
  output logic [DROP_CNT_WIDTH-1:0] drop_count,
  output logic                      overflow,
  output logic                      irq
);

  wr_action_e       wr_action;
  logic             fifo_full;
  logic             pop_eff;
  logic             wr_acc;
  logic             drop;
  logic [ENT_W-1:0] wr_entry;
  logic [CNT_W-1:0] count_next;
  logic             overflow_next;

  // The current (pre-increment) tick is used, so a packet coinciding with
  // a tick pulse is tagged with the tick that is ending.
  assign wr_entry = {tick_count, packet_in};
  assign pop_eff  = host_ren & ~host_empty & ~clear;

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_action = WR_IDLE;
    if (clear)                wr_action = WR_FLUSH;
    else if (packet_in_valid) wr_action = (!fifo_full || pop_eff) ? WR_ACCEPT : WR_DROP;
  end

  assign wr_acc = (wr_action == WR_ACCEPT);
  assign drop   = (wr_action == WR_DROP);

  spike_fifo_sync #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (clear),
    .wr_en   (wr_acc),
    .wr_data (wr_entry),
    .rd_en   (pop_eff),
    .rd_data (host_dout),
    .full    (fifo_full),
    .empty   (host_empty),
    .count   (host_count)
  );

  // irq is registered from next-state values so it moves on the same edge
  // as the occupancy or overflow change that causes it.
  always_comb begin
    count_next    = host_count + CNT_W'(wr_acc) - CNT_W'(pop_eff);
    overflow_next = overflow | drop;
    if (clear) begin
      count_next    = '0;
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_count <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (clear)     tick_count <= '0;
      else if (tick) tick_count <= tick_count + 1'b1;

      if (clear)                             drop_count <= '0;
      else if (drop && (drop_count != '1))   drop_count <= drop_count + 1'b1;

      overflow <= overflow_next;
      irq      <= (count_next >= CNT_W'(IRQ_THRESHOLD)) | overflow_next;
    end
  end

endmodule

// File: tb/tb_output_spike_buffer.sv
// Randomized and directed checking of output_spike_buffer against a
// queue-based reference model of the host-visible behaviour.
module tb_output_spike_buffer;

  localparam int DEPTH   = 64;
  localparam int THRESH  = 32;
  localparam int DROPMAX = 65535;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  packet_in;
  logic        packet_in_valid;
  logic        tick;
  logic        clear;
  logic        host_ren;
  logic [15:0] host_dout;
  logic        host_empty;
  logic [6:0]  host_count;
  logic [7:0]  tick_count;
  logic [15:0] drop_count;
  logic        overflow;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mq[$];
  int          m_tick;
  int          m_drop;
  bit          m_ovf;

  output_spike_buffer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .packet_in       (packet_in),
    .packet_in_valid (packet_in_valid),
    .tick            (tick),
    .clear           (clear),
    .host_ren        (host_ren),
    .host_dout       (host_dout),
    .host_empty      (host_empty),
    .host_count      (host_count),
    .tick_count      (tick_count),
    .drop_count      (drop_count),
    .overflow        (overflow),
    .irq             (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_tick = 0;
    m_drop = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] idx, input bit t,
                            input bit c, input bit r);
    bit          pop;
    bit          room;
    logic [15:0] e;
    if (c) begin
      model_reset();
    end else begin
      pop  = r && (mq.size() > 0);
      room = (mq.size() < DEPTH) || pop;
      e    = {m_tick[7:0], idx};
      if (pop) void'(mq.pop_front());
      if (v) begin
        if (room) mq.push_back(e);
        else begin
          if (m_drop < DROPMAX) m_drop++;
          m_ovf = 1'b1;
        end
      end
      if (t) m_tick = (m_tick + 1) % 256;
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] exp_head;
    exp_head = (mq.size() > 0) ? mq[0] : 16'h0000;
    check({tag, ".count"}, 32'(host_count), 32'(mq.size()));
    check({tag, ".empty"}, 32'(host_empty), 32'(mq.size() == 0));
    check({tag, ".dout"},  32'(host_dout),  32'(exp_head));
    check({tag, ".tick"},  32'(tick_count), 32'(m_tick));
    check({tag, ".drop"},  32'(drop_count), 32'(m_drop));
    check({tag, ".ovf"},   32'(overflow),   32'(m_ovf));
    check({tag, ".irq"},   32'(irq),        32'((mq.size() >= THRESH) || m_ovf));
  endtask

  // Called just after a rising edge; applies one cycle of inputs.
  task automatic step(input string tag, input bit v, input logic [7:0] idx,
                      input bit t, input bit c, input bit r);
    packet_in_valid = v;
    packet_in       = idx;
    tick            = t;
    clear           = c;
    host_ren        = r;
    @(posedge clk);
    model_edge(v, idx, t, c, r);
    #1;
    packet_in_valid = 1'b0;
    tick            = 1'b0;
    clear           = 1'b0;
    host_ren        = 1'b0;
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset(input string tag);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int p_valid;
    int p_ren;
    reset_n         = 1'b0;
    packet_in       = '0;
    packet_in_valid = 1'b0;
    tick            = 1'b0;
    clear           = 1'b0;
    host_ren        = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // In-order delivery with tag 0.
    step("t1_w0", 1'b1, 8'h05, 1'b0, 1'b0, 1'b0);
    step("t1_w1", 1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    step("t1_w2", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    check("t1_count3", 32'(host_count), 32'd3);
    check("t1_head0", 32'(host_dout), 32'h0005);
    step("t1_p0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t1_head1", 32'(host_dout), 32'h0010);
    step("t1_p1", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t1_head2", 32'(host_dout), 32'h00FF);
    step("t1_p2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t1_empty", 32'(host_empty), 32'd1);

    // Packet coinciding with a tick gets the pre-increment tag.
    step("t2_k0", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step("t2_k1", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step("t2_wk", 1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    check("t2_entry", 32'(host_dout), 32'h0222);
    check("t2_tick", 32'(tick_count), 32'd3);

    // Fill to full, then overrun by three.
    async_reset("t3_rst");
    for (int i = 0; i < DEPTH + 3; i++) step("t3_fill", 1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b0);
    check("t3_count", 32'(host_count), 32'd64);
    check("t3_drop", 32'(drop_count), 32'd3);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_irq", 32'(irq), 32'd1);
    check("t3_head", 32'(host_dout), 32'h0001);

    // Write with a pop at full is not a drop.
    step("t4_wp", 1'b1, 8'hAB, 1'b0, 1'b0, 1'b1);
    check("t4_count", 32'(host_count), 32'd64);
    check("t4_drop", 32'(drop_count), 32'd3);
    for (int i = 0; i < DEPTH - 1; i++) step("t4_drain", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t4_last", 32'(host_dout), 32'h00AB);
    step("t4_plast", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Write+pop on empty, then the irq threshold crossing.
    step("t5_clr", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step("t5_wpe", 1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
    check("t5_count1", 32'(host_count), 32'd1);
    for (int i = 0; i < THRESH - 2; i++) step("t5_fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    check("t5_irq_lo", 32'(irq), 32'd0);
    step("t5_w32", 1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    check("t5_irq_hi", 32'(irq), 32'd1);
    step("t5_pop", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t5_irq_fall", 32'(irq), 32'd0);

    // Clear beats a coincident packet and tick; then async reset mid-stream.
    step("t6_k", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step("t6_clr", 1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    check("t6_empty", 32'(host_empty), 32'd1);
    check("t6_tick", 32'(tick_count), 32'd0);
    for (int i = 0; i < 5; i++) step("t6_w", 1'b1, 8'(i + 8'h60), 1'b1, 1'b0, 1'b0);
    async_reset("t6_rst");
    check("t6_rst_cnt", 32'(host_count), 32'd0);

    // Randomized traffic with varying fill/drain pressure.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      case ((cyc / 250) % 4)
        0:       begin p_valid = 90; p_ren = 20; end
        1:       begin p_valid = 40; p_ren = 60; end
        2:       begin p_valid = 95; p_ren = 90; end
        default: begin p_valid = 10; p_ren = 80; end
      endcase
      if (cyc == 1700) async_reset("rnd_rst");
      step("rnd",
           ($urandom_range(99) < p_valid),
           8'($urandom),
           ($urandom_range(7) == 0),
           ($urandom_range(299) == 0),
           ($urandom_range(99) < p_ren));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
